// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard controller for the 5-stage RV32I pipeline. Detects
//            load-use hazards, sequences a multi-cycle flush after taken
//            branches/jumps, selects EX operand forwarding sources and keeps
//            hazard performance counters. State advances on the falling edge
//            of clk, in step with the pipeline registers.
// Ports    : clk, rst              - clock (falling-edge state), sync reset
//            id/ex/mem/wb_inst     - instruction words of the four stages
//            br_taken              - EX resolved a taken branch/JAL/JALR
//            stall, id_bubble      - hold PC+IF/ID, insert NOP into ID/EX
//            flush                 - kill IF/ID and ID/EX
//            fwd_a, fwd_b          - 00 regfile, 01 EX/MEM, 10 MEM/WB
//            stall_cnt, flush_cnt  - load-use stall / branch flush counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_inst,
    input  logic [31:0] ex_inst,
    input  logic [31:0] mem_inst,
    input  logic [31:0] wb_inst,
    input  logic        br_taken,
    output logic        stall,
    output logic        id_bubble,
    output logic        flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LDHOLD = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    // Flush cycles still owed after the first one (the RUN/LDHOLD cycle that
    // saw br_taken) and the FLUSH cycle that follows it.
    localparam logic [1:0] FCNT_LOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
            default:                                                   writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: reads_rs1 = 1'b1;
            default:                                              reads_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_REG, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
            default:                     reads_rs2 = 1'b0;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic [31:0] stall_cnt_q, flush_cnt_q;
    wire  [31:0] stall_cnt_d;
    wire  [31:0] flush_cnt_d;
    logic        w_stall_inc, w_flush_inc;
    logic        w_load_use;
    logic        w_mem_fwd_ok, w_wb_fwd_ok;
    logic [4:0]  w_mem_rd, w_wb_rd, w_ex_rd;
    logic        unused_bits;

    // Only opcode and register fields take part in hazard decisions.
    assign unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_inst[31:25], ex_inst[14:12],
                           mem_inst[31:12], wb_inst[31:12]};

    assign w_ex_rd  = ex_inst[11:7];
    assign w_mem_rd = mem_inst[11:7];
    assign w_wb_rd  = wb_inst[11:7];

    // A load result is not available in EX/MEM yet, so only non-loads there
    // may forward; a load in EX/MEM is covered by the earlier load-use stall.
    assign w_mem_fwd_ok = writes_rd(mem_inst[6:0]) && (mem_inst[6:0] != OP_LOAD) && (w_mem_rd != 5'd0);
    assign w_wb_fwd_ok  = writes_rd(wb_inst[6:0]) && (w_wb_rd != 5'd0);

    assign w_load_use = (ex_inst[6:0] == OP_LOAD) && (w_ex_rd != 5'd0) &&
                        ((reads_rs1(id_inst[6:0]) && (id_inst[19:15] == w_ex_rd)) ||
                         (reads_rs2(id_inst[6:0]) && (id_inst[24:20] == w_ex_rd)));

    // Forwarding selects; MEM is checked first so the youngest producer wins.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (reads_rs1(ex_inst[6:0])) begin
                if (w_mem_fwd_ok && (w_mem_rd == ex_inst[19:15]))     fwd_a = 2'b01;
                else if (w_wb_fwd_ok && (w_wb_rd == ex_inst[19:15])) fwd_a = 2'b10;
            end
            if (reads_rs2(ex_inst[6:0])) begin
                if (w_mem_fwd_ok && (w_mem_rd == ex_inst[24:20]))     fwd_b = 2'b01;
                else if (w_wb_fwd_ok && (w_wb_rd == ex_inst[24:20])) fwd_b = 2'b10;
            end
        end
    end

    // State register.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 2'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        case (state_q)
            ST_RUN, ST_LDHOLD: begin
                if (br_taken) begin
                    w_flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FCNT_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if ((state_q == ST_RUN) && w_load_use) begin
                    w_stall_inc = 1'b1;
                    state_d     = ST_LDHOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // br_taken and load-use here come from instructions being killed.
                if (fcnt_q == 2'd0) state_d = ST_RUN;
                else                fcnt_d  = fcnt_q - 2'd1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign stall_cnt_d = stall_cnt_q + {31'd0, w_stall_inc};
    assign flush_cnt_d = flush_cnt_q + {31'd0, w_flush_inc};

    // Control outputs.
    always_comb begin
        stall     = 1'b0;
        id_bubble = 1'b0;
        flush     = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN, ST_LDHOLD: begin
                    if (br_taken) begin
                        flush = 1'b1;
                    end else if ((state_q == ST_RUN) && w_load_use) begin
                        stall     = 1'b1;
                        id_bubble = 1'b1;
                    end
                end
                ST_FLUSH: flush = 1'b1;
                default: ;
            endcase
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Three instances with
//            FLUSH_CYCLES = 2, 4 and 1 share one stimulus stream; a behavioural
//            model tracks each one and is compared every cycle, and literal
//            expectations pin the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int NI = 3;

    localparam logic [31:0] NOP    = 32'h0000_0033;
    localparam logic [31:0] LW5    = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] LW3    = 32'h0000_A183; // lw   x3,0(x1)
    localparam logic [31:0] LW0    = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] LD6    = 32'h0000_A303; // lw   x6,0(x1)
    localparam logic [31:0] ADD6   = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] ADD6X0 = 32'h0022_8033; // add  x0,x5,x2
    localparam logic [31:0] ADD7   = 32'h0033_03B3; // add  x7,x6,x3
    localparam logic [31:0] ADDI6  = 32'h0050_0313; // addi x6,x0,5
    localparam logic [31:0] ADDZ   = 32'h0000_0333; // add  x6,x0,x0
    localparam logic [31:0] SW5    = 32'h0051_2023; // sw   x5,0(x2)

    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic        br  = 1'b0;
    logic [31:0] id_inst = NOP, ex_inst = NOP, mem_inst = NOP, wb_inst = NOP;

    logic        stall [NI];
    logic        bub   [NI];
    logic        flush [NI];
    logic [1:0]  fa    [NI];
    logic [1:0]  fb    [NI];
    logic [31:0] scnt  [NI];
    logic [31:0] fcnt  [NI];

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.FLUSH_CYCLES(2)) u_fc2 (
        .clk(clk), .rst(rst), .id_inst(id_inst), .ex_inst(ex_inst), .mem_inst(mem_inst),
        .wb_inst(wb_inst), .br_taken(br), .stall(stall[0]), .id_bubble(bub[0]), .flush(flush[0]),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_cnt(scnt[0]), .flush_cnt(fcnt[0]));

    hazard_ctrl #(.FLUSH_CYCLES(4)) u_fc4 (
        .clk(clk), .rst(rst), .id_inst(id_inst), .ex_inst(ex_inst), .mem_inst(mem_inst),
        .wb_inst(wb_inst), .br_taken(br), .stall(stall[1]), .id_bubble(bub[1]), .flush(flush[1]),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_cnt(scnt[1]), .flush_cnt(fcnt[1]));

    hazard_ctrl #(.FLUSH_CYCLES(1)) u_fc1 (
        .clk(clk), .rst(rst), .id_inst(id_inst), .ex_inst(ex_inst), .mem_inst(mem_inst),
        .wb_inst(wb_inst), .br_taken(br), .stall(stall[2]), .id_bubble(bub[2]), .flush(flush[2]),
        .fwd_a(fa[2]), .fwd_b(fb[2]), .stall_cnt(scnt[2]), .flush_cnt(fcnt[2]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int fc_of(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit m_wr(input logic [31:0] ins);
        return ins[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b1100111};
    endfunction
    function automatic bit m_r1(input logic [31:0] ins);
        return ins[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1100111};
    endfunction
    function automatic bit m_r2(input logic [31:0] ins);
        return ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input bit used);
        if (!used || rs == 5'd0) return 2'b00;
        if (m_wr(mem_inst) && mem_inst[6:0] != 7'b0000011 && mem_inst[11:7] == rs) return 2'b01;
        if (m_wr(wb_inst) && wb_inst[11:7] == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_loaduse();
        logic [4:0] rd;
        rd = ex_inst[11:7];
        if (ex_inst[6:0] != 7'b0000011 || rd == 5'd0) return 1'b0;
        return (m_r1(id_inst) && id_inst[19:15] == rd) || (m_r2(id_inst) && id_inst[24:20] == rd);
    endfunction

    // flush cycles still owed after the current one, and "just stalled" flag
    int          m_left [NI] = '{0, 0, 0};
    bit          m_hold [NI] = '{0, 0, 0};
    logic [31:0] m_sc   [NI] = '{0, 0, 0};
    logic [31:0] m_fc   [NI] = '{0, 0, 0};
    int          n_left [NI] = '{0, 0, 0};
    bit          n_hold [NI] = '{0, 0, 0};
    logic [31:0] n_sc   [NI] = '{0, 0, 0};
    logic [31:0] n_fc   [NI] = '{0, 0, 0};
    bit          m_valid = 1'b0;
    bit          preload = 1'b0;

    // Compare process: outputs settle in the high phase, check mid-phase.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) begin
            bit e_st, e_fl;
            logic [1:0] e_fa, e_fb;
            e_st = 1'b0; e_fl = 1'b0;
            n_left[k] = 0; n_hold[k] = 1'b0; n_sc[k] = m_sc[k]; n_fc[k] = m_fc[k];
            if (rst) begin
                e_fa = 2'b00; e_fb = 2'b00;
            end else begin
                e_fa = m_fwd(ex_inst[19:15], m_r1(ex_inst));
                e_fb = m_fwd(ex_inst[24:20], m_r2(ex_inst));
                if (m_left[k] > 0) begin
                    e_fl = 1'b1;
                    n_left[k] = m_left[k] - 1;
                end else if (br) begin
                    e_fl = 1'b1;
                    n_fc[k] = m_fc[k] + 32'd1;
                    n_left[k] = fc_of(k) - 1;
                end else if (!m_hold[k] && m_loaduse()) begin
                    e_st = 1'b1;
                    n_sc[k] = m_sc[k] + 32'd1;
                    n_hold[k] = 1'b1;
                end
            end
            chk($sformatf("stall[%0d]", k), 32'(stall[k]), 32'(e_st));
            chk($sformatf("id_bubble[%0d]", k), 32'(bub[k]), 32'(e_st));
            chk($sformatf("flush[%0d]", k), 32'(flush[k]), 32'(e_fl));
            chk($sformatf("fwd_a[%0d]", k), 32'(fa[k]), 32'(e_fa));
            chk($sformatf("fwd_b[%0d]", k), 32'(fb[k]), 32'(e_fb));
            if (m_valid) begin
                chk($sformatf("stall_cnt[%0d]", k), scnt[k], m_sc[k]);
                chk($sformatf("flush_cnt[%0d]", k), fcnt[k], m_fc[k]);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_left[k] = 0; m_hold[k] = 1'b0; m_sc[k] = 32'd0; m_fc[k] = 32'd0;
            end else begin
                m_left[k] = n_left[k]; m_hold[k] = n_hold[k]; m_sc[k] = n_sc[k]; m_fc[k] = n_fc[k];
            end
            if (preload) m_sc[k] = 32'hFFFF_FFFF;
        end
        if (rst) m_valid = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic b, input logic [31:0] i, input logic [31:0] e,
                       input logic [31:0] m, input logic [31:0] w);
        @(negedge clk);
        #1;
        rst = r; br = b; id_inst = i; ex_inst = e; mem_inst = m; wb_inst = w;
        @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(1, 0, NOP, NOP, NOP, NOP);
        cyc(1, 0, NOP, NOP, NOP, NOP);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        chk("lit_reset_stall_cnt", scnt[0], 32'd0);

        // forwarding
        cyc(0, 0, NOP, ADD7, ADD6, LW3);
        chk("lit_fwd_a_mem", 32'(fa[0]), 32'd1);
        chk("lit_fwd_b_wb", 32'(fb[0]), 32'd2);
        cyc(0, 0, NOP, ADD7, ADD6X0, LW3);
        chk("lit_fwd_a_x0", 32'(fa[0]), 32'd0);
        chk("lit_fwd_b_x0case", 32'(fb[0]), 32'd2);
        cyc(0, 0, NOP, ADD7, ADD6, ADD6);
        chk("lit_fwd_a_prio", 32'(fa[0]), 32'd1);
        cyc(0, 0, NOP, ADD7, LD6, ADD6);
        chk("lit_fwd_a_memload", 32'(fa[0]), 32'd2);
        cyc(0, 0, NOP, ADD7, LD6, NOP);
        chk("lit_fwd_a_none", 32'(fa[0]), 32'd0);

        // load-use
        cyc(0, 0, ADD6, LW5, NOP, NOP);
        chk("lit_lu_stall", 32'(stall[0]), 32'd1);
        chk("lit_lu_bubble", 32'(bub[0]), 32'd1);
        cyc(0, 0, ADD6, LW5, NOP, NOP);
        chk("lit_ldhold_stall", 32'(stall[0]), 32'd0);
        chk("lit_lu_cnt", scnt[0], 32'd1);
        cyc(0, 0, ADD6, LW5, NOP, NOP);
        chk("lit_lu_redetect", 32'(stall[0]), 32'd1);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        chk("lit_lu_cnt2", scnt[0], 32'd2);
        cyc(0, 0, ADDI6, LW5, NOP, NOP);
        chk("lit_imm_no_rs2", 32'(stall[0]), 32'd0);
        cyc(0, 0, ADDZ, LW0, NOP, NOP);
        chk("lit_x0_no_stall", 32'(stall[0]), 32'd0);
        cyc(0, 0, SW5, LW5, NOP, NOP);
        chk("lit_store_rs2", 32'(stall[0]), 32'd1);
        cyc(0, 0, NOP, NOP, NOP, NOP);

        // branch flush, second pulse in the 2nd flush cycle
        cyc(0, 1, NOP, NOP, NOP, NOP);
        chk("lit_br_flush2", 32'(flush[0]), 32'd1);
        chk("lit_br_flush1", 32'(flush[2]), 32'd1);
        cyc(0, 1, NOP, NOP, NOP, NOP);
        chk("lit_br_flush2_c2", 32'(flush[0]), 32'd1);
        chk("lit_br_fc1_again", 32'(flush[2]), 32'd1);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        chk("lit_br_flush2_end", 32'(flush[0]), 32'd0);
        chk("lit_br_flush_cnt", fcnt[0], 32'd1);
        chk("lit_br_fc4_c3", 32'(flush[1]), 32'd1);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        chk("lit_br_fc4_c4", 32'(flush[1]), 32'd1);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        chk("lit_br_fc4_end", 32'(flush[1]), 32'd0);

        // branch vs load-use priority
        cyc(0, 1, ADD6, LW5, NOP, NOP);
        chk("lit_prio_flush", 32'(flush[0]), 32'd1);
        chk("lit_prio_stall", 32'(stall[0]), 32'd0);
        cyc(0, 0, ADD6, LW5, NOP, NOP);
        chk("lit_flush_ignores_lu", 32'(stall[0]), 32'd0);
        chk("lit_prio_cnt", scnt[0], 32'd3);
        cyc(0, 0, ADD6, LW5, NOP, NOP);
        chk("lit_lu_after_flush", 32'(stall[0]), 32'd1);
        cyc(0, 1, ADD6, LW5, NOP, NOP);
        chk("lit_ldhold_br", 32'(flush[0]), 32'd1);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        cyc(0, 0, NOP, NOP, NOP, NOP);

        // reset in the 2nd flush cycle of the FLUSH_CYCLES=4 instance
        cyc(0, 1, NOP, NOP, NOP, NOP);
        chk("lit_rst_pre_flush", 32'(flush[1]), 32'd1);
        cyc(1, 0, NOP, ADD7, ADD6, LW3);
        chk("lit_rst_flush_off", 32'(flush[1]), 32'd0);
        chk("lit_rst_fwd_off", 32'(fa[1]), 32'd0);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        chk("lit_rst_no_flush", 32'(flush[1]), 32'd0);
        chk("lit_rst_scnt", scnt[1], 32'd0);
        chk("lit_rst_fcnt", fcnt[1], 32'd0);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        chk("lit_rst_no_flush2", 32'(flush[1]), 32'd0);

        // stall counter wrap
        cyc(0, 0, NOP, NOP, NOP, NOP);
        force u_fc2.stall_cnt_d = 32'hFFFF_FFFF;
        force u_fc4.stall_cnt_d = 32'hFFFF_FFFF;
        force u_fc1.stall_cnt_d = 32'hFFFF_FFFF;
        preload = 1'b1;
        @(negedge clk);
        #1;
        release u_fc2.stall_cnt_d;
        release u_fc4.stall_cnt_d;
        release u_fc1.stall_cnt_d;
        preload = 1'b0;
        cyc(0, 0, ADD6, LW5, NOP, NOP);
        chk("lit_wrap_pre", scnt[0], 32'hFFFF_FFFF);
        chk("lit_wrap_stall", 32'(stall[0]), 32'd1);
        cyc(0, 0, NOP, NOP, NOP, NOP);
        chk("lit_wrap_zero", scnt[0], 32'd0);
        cyc(0, 0, NOP, NOP, NOP, NOP);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It reads the instruction words held in the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their control inputs: `stall` to the PC and IF/ID registers, a bubble select into ID/EX, a multi-cycle flush after a taken branch or jump, and forwarding selects for the EX operand muxes. It also keeps hazard performance counters.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of consecutive cycles `flush` is asserted per taken branch or jump. Legal range 1..4.

Ports:
- `clk`  in  1  core clock. All state updates on the falling edge, matching the pipeline registers.
- `rst`  in  1  synchronous reset, active-high, sampled on the falling edge of `clk`.
- `id_inst`  in  32  instruction in IF/ID.
- `ex_inst`  in  32  instruction in ID/EX.
- `mem_inst`  in  32  instruction in EX/MEM.
- `wb_inst`  in  32  instruction in MEM/WB.
- `br_taken`  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- `stall`  out  1  hold PC and IF/ID.
- `id_bubble`  out  1  select NOP (0x00000033) as the ID/EX next instruction.
- `flush`  out  1  kill the IF/ID and ID/EX contents (both load NOP).
- `fwd_a`, `fwd_b`  out  2  EX operand source. 00 = regfile, 01 = EX/MEM alu, 10 = MEM/WB writeback data.
- `stall_cnt`  out  32  count of load-use stalls.
- `flush_cnt`  out  32  count of branch flush events.

## Operation
Instruction decode, applied to each stage's instruction word:
- rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- Writes rd: opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
- Reads rs1: opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- Reads rs2: opcodes 0110011, 0100011, 1100011.
- Register x0 never creates a hazard and is never forwarded.

Forwarding is combinational, from `ex_inst` against `mem_inst` and `wb_inst`:
- fwd_a = 01 if mem_inst writes rd ≠ 0, is not a load (0000011), and rd == ex rs1 and ex reads rs1.
- Otherwise fwd_a = 10 if wb_inst writes rd ≠ 0 and rd == ex rs1 and ex reads rs1.
- Otherwise fwd_a = 00.
- fwd_b uses the same rules with rs2.
- MEM has priority over WB.

Load-use detection: `ex_inst` is a load with rd ≠ 0, and rd matches an `id_inst` source register that the ID instruction actually reads.

FSM states are RUN, LDHOLD and FLUSH. A 2-bit flush counter `fcnt` runs alongside.

RUN:
- If br_taken: `flush`=1, `stall`=0, `id_bubble`=0, flush_cnt += 1. If FLUSH_CYCLES > 1, go to FLUSH with fcnt = FLUSH_CYCLES-2; otherwise stay in RUN.
- Else if load-use: `stall`=1, `id_bubble`=1, stall_cnt += 1, go to LDHOLD.
- Else: all control outputs 0.
- br_taken has priority over load-use in the same cycle. Only the flush is taken.

LDHOLD:
- Lasts exactly one cycle. Load-use detection is suppressed. `stall`=0, `id_bubble`=0.
- br_taken is honoured here exactly as in RUN. Otherwise go to RUN.

FLUSH:
- `flush`=1, `stall`=0, `id_bubble`=0.
- br_taken and load-use are both ignored, because they come from killed instructions.
- If fcnt == 0, go to RUN; else fcnt -= 1.

Counters:
- Unsigned 32-bit, wrap 0xFFFFFFFF → 0.
- Each counter increments at most once per cycle.

## Timing
- Control outputs (`stall`, `id_bubble`, `flush`, `fwd_*`) are combinational from the inputs and the current state, with zero latency. They must settle within the high phase so the pipeline registers sample them on the falling edge.
- While `rst`=1, all control outputs are forced to 0.
- Reset on a falling edge with `rst`=1 sets state=RUN, fcnt=0, stall_cnt=0, flush_cnt=0.
- Reset mid-FLUSH or mid-LDHOLD aborts the sequence. The first cycle after reset is RUN.
- A taken branch in cycle N gives `flush`=1 for cycles N .. N+FLUSH_CYCLES-1.
- A load-use in cycle N gives `stall`=1 only in cycle N.
- Back-to-back loads whose hazards are re-detected after LDHOLD produce one stall per detection.

## Test plan
- Load-use: ex_inst=0x0000A283 (lw x5,0(x1)), id_inst=0x00228333 (add x6,x5,x2). Required: `stall`=`id_bubble`=1 for one cycle, 0 in the next cycle, stall_cnt=1.
- Forwarding: ex_inst=0x003303B3 (add x7,x6,x3), mem_inst=0x00228333, wb_inst=0x0000A183 (lw x3). Required: fwd_a=01, fwd_b=10. Repeat with mem_inst rd=x0. Required: fwd_a=00.
- Branch flush: br_taken=1 for one cycle with FLUSH_CYCLES=2. Required: `flush`=1 for exactly 2 cycles, flush_cnt=1. A second br_taken pulse during the second flush cycle must be ignored.
- Priority: br_taken=1 together with a load-use. Required: `flush`=1, `stall`=0, stall_cnt unchanged.
- Reset mid-FLUSH with FLUSH_CYCLES=4: assert `rst` in the 2nd flush cycle. Required: all outputs 0 and counters 0 on the next cycle, with no further flush.
- Counter wrap: force 0xFFFFFFFF stall events, then trigger one more load-use. Required: stall_cnt=0.
